// File: rtl/sequence_store.sv
// sequence_store: storage for the Simon Says round sequence.
//
// Holds up to DEPTH steps, each a channel index. Steps are appended one at a
// time; a read pointer walks the stored steps for playback and input checking.
// The addressed step is presented as an index and as an active-low one-hot
// LED pattern.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          asynchronous, active-high reset
//   clear_i        empty the sequence and zero the pointer (synchronous)
//   append_i       write append_idx_i at position length, then length+1
//   append_idx_i   channel index to append
//   rewind_i       pointer := 0
//   advance_i      pointer := pointer+1, saturating or wrapping per WRAP
//   rd_idx_o       index stored at the pointer (0 when empty)
//   rd_onehot_n_o  active-low one-hot of rd_idx_o (all ones when empty)
//   rd_ptr_o       current pointer
//   length_o       number of valid steps
//   empty_o        length == 0
//   full_o         length == DEPTH
//   last_o         pointer addresses the final valid step
//   append_err_o   one-cycle pulse after an append rejected while full
module sequence_store #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WRAP     = 0,
    localparam int unsigned IW = $clog2(CHANNELS),
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned LW = $clog2(DEPTH + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic                append_i,
    input  logic [IW-1:0]       append_idx_i,
    input  logic                rewind_i,
    input  logic                advance_i,
    output logic [IW-1:0]       rd_idx_o,
    output logic [CHANNELS-1:0] rd_onehot_n_o,
    output logic [PW-1:0]       rd_ptr_o,
    output logic [LW-1:0]       length_o,
    output logic                empty_o,
    output logic                full_o,
    output logic                last_o,
    output logic                append_err_o
);

    logic [IW-1:0] mem_q [DEPTH];
    logic [IW-1:0] mem_d [DEPTH];
    logic [LW-1:0] length_q, length_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          err_q, err_d;

    logic          empty, full, last;
    logic [IW-1:0] rd_raw;

    // Status and read path, all combinational from registers.
    always_comb begin
        empty = (length_q == '0);
        full  = (length_q == LW'(DEPTH));
        last  = !empty && (LW'(ptr_q) == length_q - LW'(1));

        // Decoded read keeps non-power-of-two DEPTH free of out-of-range indexing.
        rd_raw = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ptr_q == PW'(i)) rd_raw = mem_q[i];
        end
    end

    always_comb begin
        rd_idx_o = empty ? '0 : rd_raw;
        // Indices >= CHANNELS match no bit, so they light nothing.
        rd_onehot_n_o = '1;
        for (int c = 0; c < CHANNELS; c++) begin
            if (!empty && (rd_idx_o == IW'(c))) rd_onehot_n_o[c] = 1'b0;
        end
        rd_ptr_o     = ptr_q;
        length_o     = length_q;
        empty_o      = empty;
        full_o       = full;
        last_o       = last;
        append_err_o = err_q;
    end

    // Next state. Pointer decisions use the pre-edge length, so a same-cycle
    // append never changes that cycle's advance.
    always_comb begin
        mem_d    = mem_q;
        length_d = length_q;
        ptr_d    = ptr_q;
        err_d    = 1'b0;

        if (clear_i) begin
            length_d = '0;
        end else if (append_i) begin
            if (full) begin
                err_d = 1'b1;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (length_q == LW'(i)) mem_d[i] = append_idx_i;
                end
                length_d = length_q + LW'(1);
            end
        end

        if (clear_i || rewind_i) begin
            ptr_d = '0;
        end else if (advance_i && !empty) begin
            if (last) begin
                ptr_d = (WRAP != 0) ? '0 : ptr_q;
            end else begin
                ptr_d = ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            length_q <= '0;
            ptr_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            length_q <= length_d;
            ptr_q    <= ptr_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_sequence_store.sv
// Self-checking bench for sequence_store (DEPTH=16, CHANNELS=4). Two instances
// share all inputs: one with WRAP=0, one with WRAP=1.
module tb_sequence_store;

    localparam int unsigned DEPTH    = 16;
    localparam int unsigned CHANNELS = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear, append, rewind, advance;
    logic [1:0] append_idx;

    logic [1:0] rd_idx,   w_rd_idx;
    logic [3:0] onehot_n, w_onehot_n;
    logic [3:0] rd_ptr,   w_rd_ptr;
    logic [4:0] length,   w_length;
    logic       empty, full, last, err;
    logic       w_empty, w_full, w_last, w_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sequence_store #(.DEPTH(DEPTH), .CHANNELS(CHANNELS), .WRAP(0)) u_dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .append_i(append),
        .append_idx_i(append_idx), .rewind_i(rewind), .advance_i(advance),
        .rd_idx_o(rd_idx), .rd_onehot_n_o(onehot_n), .rd_ptr_o(rd_ptr),
        .length_o(length), .empty_o(empty), .full_o(full), .last_o(last),
        .append_err_o(err)
    );

    sequence_store #(.DEPTH(DEPTH), .CHANNELS(CHANNELS), .WRAP(1)) u_dut_w (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .append_i(append),
        .append_idx_i(append_idx), .rewind_i(rewind), .advance_i(advance),
        .rd_idx_o(w_rd_idx), .rd_onehot_n_o(w_onehot_n), .rd_ptr_o(w_rd_ptr),
        .length_o(w_length), .empty_o(w_empty), .full_o(w_full), .last_o(w_last),
        .append_err_o(w_err)
    );

    typedef struct {
        logic       clr, app;
        logic [1:0] idx;
        logic       rew, adv;
        logic [4:0] len;
        logic [3:0] ptr;
        logic [1:0] ridx;
        logic [3:0] oh;
        logic       emp, ful, lst, err;
        logic [3:0] ptrw;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    function automatic vec_t mk(input logic c, a, input logic [1:0] ix, input logic r, v,
                                input logic [4:0] len, input logic [3:0] ptr,
                                input logic [1:0] ridx, input logic [3:0] oh,
                                input logic emp, lst, input logic [3:0] ptrw);
        vec_t t;
        t.clr = c; t.app = a; t.idx = ix; t.rew = r; t.adv = v;
        t.len = len; t.ptr = ptr; t.ridx = ridx; t.oh = oh;
        t.emp = emp; t.ful = 1'b0; t.lst = lst; t.err = 1'b0; t.ptrw = ptrw;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic c, a, input logic [1:0] ix, input logic r, v);
        clear = c; append = a; append_idx = ix; rewind = r; advance = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input string tag, input vec_t e);
        check({tag, " length"}, 32'(length), 32'(e.len));
        check({tag, " rd_ptr"}, 32'(rd_ptr), 32'(e.ptr));
        check({tag, " rd_idx"}, 32'(rd_idx), 32'(e.ridx));
        check({tag, " onehot_n"}, 32'(onehot_n), 32'(e.oh));
        check({tag, " empty"}, 32'(empty), 32'(e.emp));
        check({tag, " full"}, 32'(full), 32'(e.ful));
        check({tag, " last"}, 32'(last), 32'(e.lst));
        check({tag, " append_err"}, 32'(err), 32'(e.err));
        check({tag, " wrap rd_ptr"}, 32'(w_rd_ptr), 32'(e.ptrw));
    endtask

    initial begin
        vec_t cur, e;

        //           clr app idx rew adv | len ptr ridx oh      emp lst ptrw
        vecs.push_back(mk(0, 1, 2'd0, 0, 0, 5'd1, 4'd0, 2'd0, 4'b1110, 0, 1, 4'd0));
        vecs.push_back(mk(1, 0, 2'd0, 0, 0, 5'd0, 4'd0, 2'd0, 4'b1111, 1, 0, 4'd0));
        vecs.push_back(mk(0, 1, 2'd2, 0, 0, 5'd1, 4'd0, 2'd2, 4'b1011, 0, 1, 4'd0));
        vecs.push_back(mk(0, 1, 2'd1, 0, 0, 5'd2, 4'd0, 2'd2, 4'b1011, 0, 0, 4'd0));
        vecs.push_back(mk(0, 1, 2'd3, 0, 0, 5'd3, 4'd0, 2'd2, 4'b1011, 0, 0, 4'd0));
        vecs.push_back(mk(0, 1, 2'd0, 0, 0, 5'd4, 4'd0, 2'd2, 4'b1011, 0, 0, 4'd0));
        vecs.push_back(mk(0, 0, 2'd0, 1, 0, 5'd4, 4'd0, 2'd2, 4'b1011, 0, 0, 4'd0));
        vecs.push_back(mk(0, 0, 2'd0, 0, 1, 5'd4, 4'd1, 2'd1, 4'b1101, 0, 0, 4'd1));
        vecs.push_back(mk(0, 0, 2'd0, 0, 1, 5'd4, 4'd2, 2'd3, 4'b0111, 0, 0, 4'd2));
        vecs.push_back(mk(0, 0, 2'd0, 0, 1, 5'd4, 4'd3, 2'd0, 4'b1110, 0, 1, 4'd3));
        // Advance at the last step: hold vs wrap.
        vecs.push_back(mk(0, 0, 2'd0, 0, 1, 5'd4, 4'd3, 2'd0, 4'b1110, 0, 1, 4'd0));
        // Append + advance while last: pointer holds, length grows.
        vecs.push_back(mk(0, 1, 2'd1, 0, 1, 5'd5, 4'd3, 2'd0, 4'b1110, 0, 0, 4'd1));
        // Rewind beats advance.
        vecs.push_back(mk(0, 0, 2'd0, 1, 1, 5'd5, 4'd0, 2'd2, 4'b1011, 0, 0, 4'd0));
        // Clear beats append and advance; no append_err.
        vecs.push_back(mk(1, 1, 2'd2, 0, 1, 5'd0, 4'd0, 2'd0, 4'b1111, 1, 0, 4'd0));
        // Advance while empty is ignored.
        vecs.push_back(mk(0, 0, 2'd0, 0, 1, 5'd0, 4'd0, 2'd0, 4'b1111, 1, 0, 4'd0));
        // Build length 3 (1,2,3) and walk to the end, then hold advance.
        vecs.push_back(mk(0, 1, 2'd1, 0, 0, 5'd1, 4'd0, 2'd1, 4'b1101, 0, 1, 4'd0));
        vecs.push_back(mk(0, 1, 2'd2, 0, 0, 5'd2, 4'd0, 2'd1, 4'b1101, 0, 0, 4'd0));
        vecs.push_back(mk(0, 1, 2'd3, 0, 0, 5'd3, 4'd0, 2'd1, 4'b1101, 0, 0, 4'd0));
        vecs.push_back(mk(0, 0, 2'd0, 0, 1, 5'd3, 4'd1, 2'd2, 4'b1011, 0, 0, 4'd1));
        vecs.push_back(mk(0, 0, 2'd0, 0, 1, 5'd3, 4'd2, 2'd3, 4'b0111, 0, 1, 4'd2));
        vecs.push_back(mk(0, 0, 2'd0, 0, 1, 5'd3, 4'd2, 2'd3, 4'b0111, 0, 1, 4'd0));
        vecs.push_back(mk(0, 0, 2'd0, 0, 1, 5'd3, 4'd2, 2'd3, 4'b0111, 0, 1, 4'd1));

        // Reset state, checked while reset is held.
        rst = 1'b1;
        drive(0, 0, 2'd0, 0, 0);
        #12;
        check("reset length", 32'(length), 32'd0);
        check("reset rd_ptr", 32'(rd_ptr), 32'd0);
        check("reset empty", 32'(empty), 32'd1);
        check("reset full", 32'(full), 32'd0);
        check("reset last", 32'(last), 32'd0);
        check("reset onehot_n", 32'(onehot_n), 32'hf);
        check("reset rd_idx", 32'(rd_idx), 32'd0);
        check("reset append_err", 32'(err), 32'd0);
        rst = 1'b0;
        tick();

        // Table vectors via scoreboard: expectation queued when driven, popped after the edge.
        for (int i = 0; i < vecs.size(); i++) begin
            cur = vecs[i];
            drive(cur.clr, cur.app, cur.idx, cur.rew, cur.adv);
            exp_q.push_back(cur);
            tick();
            e = exp_q.pop_front();
            check_vec($sformatf("vec%0d", i), e);
        end

        // Overflow: fill 16 entries, then rejected appends.
        drive(1, 0, 2'd0, 0, 0);
        tick();
        for (int k = 0; k < 16; k++) begin
            drive(0, 1, 2'(k % 4), 0, 0);
            tick();
            check($sformatf("fill%0d length", k), 32'(length), 32'(k + 1));
            check($sformatf("fill%0d full", k), 32'(full), 32'(k == 15));
        end
        drive(0, 1, 2'd0, 0, 0);
        tick();
        check("ovf1 append_err", 32'(err), 32'd1);
        check("ovf1 length", 32'(length), 32'd16);
        tick();
        check("ovf2 append_err held", 32'(err), 32'd1);
        drive(0, 0, 2'd0, 0, 0);
        tick();
        check("ovf idle append_err", 32'(err), 32'd0);
        check("ovf idle full", 32'(full), 32'd1);
        for (int k = 0; k < 15; k++) begin
            drive(0, 0, 2'd0, 0, 1);
            tick();
        end
        drive(0, 0, 2'd0, 0, 0);
        check("ovf mem15 rd_ptr", 32'(rd_ptr), 32'd15);
        check("ovf mem15 rd_idx", 32'(rd_idx), 32'd3);
        check("ovf mem15 onehot_n", 32'(onehot_n), 32'b0111);
        check("ovf mem15 last", 32'(last), 32'd1);

        // Async reset: length 5, pointer 3, reset pulsed between edges.
        drive(1, 0, 2'd0, 0, 0);
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, 2'(k % 4), 0, 0);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 2'd0, 0, 1);
            tick();
        end
        drive(0, 0, 2'd0, 0, 0);
        check("pre-rst length", 32'(length), 32'd5);
        check("pre-rst rd_ptr", 32'(rd_ptr), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("async length", 32'(length), 32'd0);
        check("async rd_ptr", 32'(rd_ptr), 32'd0);
        check("async empty", 32'(empty), 32'd1);
        check("async onehot_n", 32'(onehot_n), 32'hf);
        check("async last", 32'(last), 32'd0);
        #1;
        rst = 1'b0;
        tick();
        check("post-rst length", 32'(length), 32'd0);
        check("post-rst empty", 32'(empty), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
